// File: rtl/fir_stats_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fir_stats_pkg                                                     |
// | Desc   : Shared types, default widths and saturating adders for the        |
// |          approximate-vs-accurate error statistics engine.                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package fir_stats_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 64;
    localparam int DEF_SQ_W   = 96;
    localparam int DEF_CNT_W  = 32;
    // Working width of the saturating adders; must exceed every accumulator width.
    localparam int SAT_W      = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [SAT_W-1:0] sat_word_t;

    typedef struct packed {
        logic      sat;
        sat_word_t sum;
    } sat_res_t;

    // Operands arrive sign-extended to SAT_W; the result clamps to +/-(2^(w-1)-1).
    function automatic sat_res_t sat_add_s(input sat_word_t a, input sat_word_t b,
                                           input int unsigned w);
        sat_res_t                res;
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] lim;
        sum     = $signed(a) + $signed(b);
        lim     = $signed((sat_word_t'(1) << (w - 1)) - sat_word_t'(1));
        res.sat = 1'b0;
        res.sum = sat_word_t'(sum);
        if (sum > lim) begin
            res.sat = 1'b1;
            res.sum = sat_word_t'(lim);
        end else if (sum < -lim) begin
            res.sat = 1'b1;
            res.sum = sat_word_t'(-lim);
        end
        return res;
    endfunction

    // Operands arrive zero-extended to SAT_W; the result clamps to 2^w-1.
    function automatic sat_res_t sat_add_u(input sat_word_t a, input sat_word_t b,
                                           input int unsigned w);
        sat_res_t  res;
        sat_word_t sum;
        sat_word_t lim;
        sum     = a + b;
        lim     = (sat_word_t'(1) << w) - sat_word_t'(1);
        res.sat = 1'b0;
        res.sum = sum;
        if (sum > lim) begin
            res.sat = 1'b1;
            res.sum = lim;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_err_acc_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fir_err_acc_stage                                                 |
// | Desc   : Two-stage error datapath: S1 forms error and magnitudes, S2       |
// |          squares and accumulates with saturation and tracks peak error.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fir_err_acc_stage
    import fir_stats_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SQ_W   = DEF_SQ_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] appr,
    input  logic [DATA_W-1:0] accu,
    output logic              s1_vld,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [ACC_W-1:0]  err_sum,
    output logic [SQ_W-1:0]   err_sq_sum,
    output logic [ACC_W-1:0]  abs_sum,
    output logic [DATA_W:0]   max_abs_err,
    output logic              ovf
);

    localparam int EW = DATA_W + 1;

    logic              s1_vld_q, s1_vld_d;
    logic [EW-1:0]     e_q, e_d;
    logic [EW-1:0]     abs_e_q, abs_e_d;
    logic [EW-1:0]     abs_accu_q, abs_accu_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [ACC_W-1:0]  err_sum_q, err_sum_d;
    logic [SQ_W-1:0]   err_sq_sum_q, err_sq_sum_d;
    logic [ACC_W-1:0]  abs_sum_q, abs_sum_d;
    logic [EW-1:0]     max_abs_err_q, max_abs_err_d;
    logic              ovf_q, ovf_d;

    logic [EW-1:0]     w_appr_x, w_accu_x, w_e;
    logic [2*EW-1:0]   w_sq;
    sat_res_t          w_err_r, w_sq_r, w_abs_r;
    logic              w_unused_sat;

    // S1: one extra bit keeps appr-accu and |accu| exact for every input pair.
    always_comb begin
        w_appr_x   = {appr[DATA_W-1], appr};
        w_accu_x   = {accu[DATA_W-1], accu};
        w_e        = w_appr_x - w_accu_x;
        s1_vld_d   = in_vld & ~clr;
        e_d        = e_q;
        abs_e_d    = abs_e_q;
        abs_accu_d = abs_accu_q;
        if (in_vld) begin
            e_d        = w_e;
            abs_e_d    = w_e[EW-1] ? -w_e : w_e;
            abs_accu_d = w_accu_x[EW-1] ? -w_accu_x : w_accu_x;
        end
    end

    always_comb begin
        w_sq    = {{EW{1'b0}}, abs_e_q} * {{EW{1'b0}}, abs_e_q};
        w_err_r = sat_add_s({{(SAT_W-ACC_W){err_sum_q[ACC_W-1]}}, err_sum_q},
                            {{(SAT_W-EW){e_q[EW-1]}}, e_q}, ACC_W);
        w_sq_r  = sat_add_u(sat_word_t'(err_sq_sum_q), sat_word_t'(w_sq), SQ_W);
        w_abs_r = sat_add_u(sat_word_t'(abs_sum_q), sat_word_t'(abs_accu_q), ACC_W);
        w_unused_sat = ^{w_err_r.sum[SAT_W-1:ACC_W], w_sq_r.sum[SAT_W-1:SQ_W],
                         w_abs_r.sum[SAT_W-1:ACC_W]};

        sample_cnt_d  = sample_cnt_q;
        err_sum_d     = err_sum_q;
        err_sq_sum_d  = err_sq_sum_q;
        abs_sum_d     = abs_sum_q;
        max_abs_err_d = max_abs_err_q;
        ovf_d         = ovf_q;
        if (clr) begin
            sample_cnt_d  = '0;
            err_sum_d     = '0;
            err_sq_sum_d  = '0;
            abs_sum_d     = '0;
            max_abs_err_d = '0;
            ovf_d         = 1'b0;
        end else if (s1_vld_q) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            err_sum_d    = w_err_r.sum[ACC_W-1:0];
            err_sq_sum_d = w_sq_r.sum[SQ_W-1:0];
            abs_sum_d    = w_abs_r.sum[ACC_W-1:0];
            if (abs_e_q > max_abs_err_q) begin
                max_abs_err_d = abs_e_q;
            end
            ovf_d = ovf_q | w_err_r.sat | w_sq_r.sat | w_abs_r.sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q      <= 1'b0;
            e_q           <= '0;
            abs_e_q       <= '0;
            abs_accu_q    <= '0;
            sample_cnt_q  <= '0;
            err_sum_q     <= '0;
            err_sq_sum_q  <= '0;
            abs_sum_q     <= '0;
            max_abs_err_q <= '0;
            ovf_q         <= 1'b0;
        end else begin
            s1_vld_q      <= s1_vld_d;
            e_q           <= e_d;
            abs_e_q       <= abs_e_d;
            abs_accu_q    <= abs_accu_d;
            sample_cnt_q  <= sample_cnt_d;
            err_sum_q     <= err_sum_d;
            err_sq_sum_q  <= err_sq_sum_d;
            abs_sum_q     <= abs_sum_d;
            max_abs_err_q <= max_abs_err_d;
            ovf_q         <= ovf_d;
        end
    end

    assign s1_vld      = s1_vld_q;
    assign sample_cnt  = sample_cnt_q;
    assign err_sum     = err_sum_q;
    assign err_sq_sum  = err_sq_sum_q;
    assign abs_sum     = abs_sum_q;
    assign max_abs_err = max_abs_err_q;
    assign ovf         = ovf_q;

endmodule
`default_nettype wire

// File: rtl/fir_err_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fir_err_stats                                                     |
// | Desc   : Windowed error-statistics engine: control FSM, accept counter     |
// |          and valid/ready handshake around the accumulate datapath.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fir_err_stats
    import fir_stats_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SQ_W   = DEF_SQ_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] appr,
    input  logic [DATA_W-1:0] accu,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [ACC_W-1:0]  err_sum,
    output logic [SQ_W-1:0]   err_sq_sum,
    output logic [ACC_W-1:0]  abs_sum,
    output logic [DATA_W:0]   max_abs_err,
    output logic              ovf
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             w_accept;
    logic             w_clr;
    logic             w_s1_vld;
    logic [CNT_W-1:0] w_cnt_inc;

    always_comb begin
        w_accept  = in_valid & in_ready_q;
        w_clr     = (state_q == IDLE) & start;
        w_cnt_inc = acc_cnt_q + CNT_W'(1);
        state_d   = state_q;
        n_d       = n_q;
        acc_cnt_d = acc_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d       = num_samples;
                    acc_cnt_d = '0;
                    state_d   = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_accept) begin
                    acc_cnt_d = w_cnt_inc;
                    if (w_cnt_inc == n_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            // S1 empty here means S2 has absorbed the final pair on this edge.
            DRAIN:   if (!w_s1_vld) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == RUN);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            acc_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            acc_cnt_q  <= acc_cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    fir_err_acc_stage #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SQ_W   (SQ_W),
        .CNT_W  (CNT_W)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clr         (w_clr),
        .in_vld      (w_accept),
        .appr        (appr),
        .accu        (accu),
        .s1_vld      (w_s1_vld),
        .sample_cnt  (sample_cnt),
        .err_sum     (err_sum),
        .err_sq_sum  (err_sq_sum),
        .abs_sum     (abs_sum),
        .max_abs_err (max_abs_err),
        .ovf         (ovf)
    );

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_err_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fir_err_stats                                                  |
// | Desc   : Directed self-checking bench for fir_err_stats (default widths   |
// |          plus a narrow-accumulator instance for saturation).              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_fir_err_stats;

    localparam int DW  = 32;
    localparam int AW  = 64;
    localparam int SW  = 96;
    localparam int CW  = 32;
    localparam int AWS = 33;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_samples = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] appr = '0;
    logic [DW-1:0] accu = '0;

    logic          in_ready, busy, done, ovf;
    logic [CW-1:0] sample_cnt;
    logic [AW-1:0] err_sum, abs_sum;
    logic [SW-1:0] err_sq_sum;
    logic [DW:0]   max_abs_err;

    logic           s_in_ready, s_busy, s_done, s_ovf;
    logic [CW-1:0]  s_sample_cnt;
    logic [AWS-1:0] s_err_sum, s_abs_sum;
    logic [SW-1:0]  s_err_sq_sum;
    logic [DW:0]    s_max_abs_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] pa [4];
    logic [DW-1:0] pb [4];

    always #5 clk = ~clk;

    fir_err_stats #(.DATA_W(DW), .ACC_W(AW), .SQ_W(SW), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .appr(appr), .accu(accu),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_sum(err_sum),
        .err_sq_sum(err_sq_sum), .abs_sum(abs_sum), .max_abs_err(max_abs_err),
        .ovf(ovf)
    );

    fir_err_stats #(.DATA_W(DW), .ACC_W(AWS), .SQ_W(SW), .CNT_W(CW)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(s_in_ready), .appr(appr), .accu(accu),
        .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .err_sum(s_err_sum),
        .err_sq_sum(s_err_sq_sum), .abs_sum(s_abs_sum), .max_abs_err(s_max_abs_err),
        .ovf(s_ovf)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        start       = 1'b1;
        num_samples = n;
        tick();
        start       = 1'b0;
        num_samples = 32'hdead_beef;
    endtask

    // Offers pa/pb[first..last-1]; off-cycles carry junk data that must be ignored.
    task automatic feed(input string t, input int first, input int last, input bit toggle);
        int idx   = first;
        int guard = 0;
        bit ph    = 1'b1;
        bit acc;
        while (idx < last && guard < 100) begin
            in_valid = toggle ? ph : 1'b1;
            if (in_valid) begin
                appr = pa[idx];
                accu = pb[idx];
            end else begin
                appr = 32'h5555_5555;
                accu = 32'haaaa_aaaa;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            ph = ~ph;
            guard++;
        end
        in_valid = 1'b0;
        if (idx < last) check_eq({t, "_feed_timeout"}, idx, last);
    endtask

    task automatic wait_done(input string t, input int exp_lat);
        int k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        check_eq({t, "_done_lat"}, k, exp_lat);
    endtask

    task automatic check_results(input string t, input logic [CW-1:0] cnt, input logic [AW-1:0] es,
                                 input logic [SW-1:0] sq, input logic [AW-1:0] ab,
                                 input logic [DW:0] mx, input logic ov);
        check_eq({t, "_sample_cnt"},  sample_cnt,  cnt);
        check_eq({t, "_err_sum"},     err_sum,     es);
        check_eq({t, "_err_sq_sum"},  err_sq_sum,  sq);
        check_eq({t, "_abs_sum"},     abs_sum,     ab);
        check_eq({t, "_max_abs_err"}, max_abs_err, mx);
        check_eq({t, "_ovf"},         ovf,         ov);
    endtask

    task automatic load_basic();
        pa[0] = 32'd10;          pb[0] = 32'd7;
        pa[1] = 32'd5;           pb[1] = 32'd5;
        pa[2] = -32'sd3;         pb[2] = 32'd2;
        pa[3] = 32'd100;         pb[3] = 32'd90;
    endtask

    initial begin
        repeat (3) tick();
        check_eq("rst_ctrl", {busy, done, in_ready, ovf, s_ovf}, 5'b0);
        check_eq("rst_cnt", sample_cnt, 0);
        check_eq("rst_err_sum", err_sum, 0);
        check_eq("rst_sums", {err_sq_sum, abs_sum, max_abs_err}, 0);
        rst = 1'b0;
        tick();

        // Contiguous window
        load_basic();
        do_start(4);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_ready", in_ready, 1);
        feed("t1", 0, 4, 1'b0);
        check_eq("t1_ready_low", in_ready, 0);
        wait_done("t1", 2);
        check_results("t1", 4, 64'd8, 96'd134, 64'd104, 33'd10, 1'b0);
        tick();
        check_eq("t1_pulse", done, 0);
        check_eq("t1_busy_low", busy, 0);
        repeat (3) tick();
        check_eq("t1_hold", err_sum, 64'd8);

        // Bubbled window
        do_start(4);
        check_eq("t2_cleared", err_sum, 0);
        feed("t2", 0, 4, 1'b1);
        check_eq("t2_ready_low", in_ready, 0);
        wait_done("t2", 2);
        check_results("t2", 4, 64'd8, 96'd134, 64'd104, 33'd10, 1'b0);
        tick();

        // start during RUN must not disturb the latched window length
        do_start(4);
        feed("t3", 0, 2, 1'b0);
        start       = 1'b1;
        num_samples = 32'd1;
        tick();
        start       = 1'b0;
        check_eq("t3_ready_kept", in_ready, 1);
        feed("t3", 2, 4, 1'b0);
        check_eq("t3_ready_low", in_ready, 0);
        wait_done("t3", 2);
        check_results("t3", 4, 64'd8, 96'd134, 64'd104, 33'd10, 1'b0);
        tick();

        // Reset mid-window
        do_start(4);
        feed("t4", 0, 2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4_ctrl", {busy, done, in_ready, ovf}, 4'b0);
        check_eq("t4_data", {sample_cnt, err_sum, abs_sum, max_abs_err}, 0);
        check_eq("t4_sq", err_sq_sum, 0);
        begin
            int seen = 0;
            in_valid = 1'b1;
            repeat (6) begin
                tick();
                if (done || in_ready) seen++;
            end
            in_valid = 1'b0;
            check_eq("t4_quiet", seen, 0);
        end

        // Extreme operands: saturation on the 33-bit instance, exact on the default
        for (int i = 0; i < 3; i++) begin
            pa[i] = 32'h7fff_ffff;
            pb[i] = 32'h8000_0000;
        end
        do_start(3);
        feed("t5", 0, 3, 1'b0);
        wait_done("t5", 2);
        check_eq("t5_sat_err_sum", s_err_sum, 33'h0_ffff_ffff);
        check_eq("t5_sat_ovf", s_ovf, 1);
        check_eq("t5_sat_abs_sum", s_abs_sum, 33'h1_8000_0000);
        check_results("t5", 3, 64'd12884901885, 96'h2_ffff_fffa_0000_0003,
                      64'h1_8000_0000, 33'h0_ffff_ffff, 1'b0);
        tick();

        // Zero-length window; also clears the sticky overflow
        do_start(0);
        check_eq("t6_done", done, 1);
        check_eq("t6_busy", busy, 1);
        check_eq("t6_ready", in_ready, 0);
        check_eq("t6_ovf_clr", s_ovf, 0);
        check_eq("t6_zero", {sample_cnt, err_sum, abs_sum, max_abs_err}, 0);
        tick();
        check_eq("t6_after", {done, busy}, 2'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fir_err_stats.md
Name: fir_err_stats

Overview:
- Streaming hardware error-statistics engine for approximate-vs-accurate datapath comparison (e.g. fir_variance against fir_accurate).
- Accepts sample pairs (approximate, accurate) over a valid/ready handshake for a programmed window of N samples.
- Accumulates error sum, error-squared sum, absolute accurate-result sum and peak absolute error; signals completion with a pulse.
- Sits beside the DUT pair in emulation/FPGA builds, replacing software-side statistics. Host divides the sums to get mean and variance.

Parameters:
- DATA_W, 32, width of the signed appr/accu samples.
- ACC_W, 64, width of err_sum and abs_sum accumulators.
- SQ_W, 96, width of the err_sq_sum accumulator.
- CNT_W, 32, width of the sample counter and num_samples.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a window; sampled only in IDLE.
- num_samples  in  CNT_W  window length, latched on an accepted start.
- in_valid  in  1  appr/accu pair valid.
- in_ready  out  1  high only in RUN while accepted count < latched N.
- appr  in  DATA_W  signed approximate result.
- accu  in  DATA_W  signed accurate result.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse; results are stable from this cycle until the next accepted start.
- sample_cnt  out  CNT_W  pairs accumulated in the current or last window.
- err_sum  out  ACC_W  signed sum of (appr-accu).
- err_sq_sum  out  SQ_W  unsigned sum of (appr-accu)^2.
- abs_sum  out  ACC_W  unsigned sum of |accu|.
- max_abs_err  out  DATA_W+1  unsigned peak |appr-accu|.
- ovf  out  1  sticky; set if any accumulator saturated in the window.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset state:
  - FSM IDLE; all outputs 0.
  - rst mid-window aborts immediately; no done pulse; pipeline contents discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE:
    - start=1 latches N, clears all accumulators, counters and ovf.
    - N>0: go to RUN.
    - N==0: go to DONE; results all zero.
  - RUN:
    - Accept a pair when in_valid && in_ready.
    - in_ready drops the cycle after the Nth accept; go to DRAIN.
  - DRAIN: wait until the 2-stage pipeline is empty (2 cycles), then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Pipeline (per accepted pair):
  - S1 registers e = sign-extended appr - accu (DATA_W+1 bits, no overflow), |e|, and |accu| (DATA_W+1 bits, so |-2^(DATA_W-1)| is exact).
  - S2 adds e into err_sum, e*e into err_sq_sum and |accu| into abs_sum; updates max_abs_err and sample_cnt.
  - Last accept to done: 3 cycles (S1, S2, DONE).
- Saturation:
  - err_sum saturates to ±(2^(ACC_W-1)-1).
  - err_sq_sum and abs_sum saturate to all-ones.
  - Any saturation sets ovf; ovf stays set until the next accepted start.
- in_valid low in RUN inserts bubbles; no state change.
- appr/accu are ignored when not accepted.
- Outputs update live during RUN. They are architecturally valid only at done and stay held in IDLE.

Decomposition:
- Package fir_stats_pkg:
  - state_t enum (IDLE, RUN, DRAIN, DONE).
  - Default width localparams.
  - sat_add_s / sat_add_u functions.
- Sub-module fir_err_acc_stage: the S1/S2 datapath (error, abs, square, saturating accumulate, max tracking), with a valid-in and clear input.
- The top holds the FSM, counter and handshake.

Test Plan:
- num_samples=4; pairs (10,7), (5,5), (-3,2), (100,90) with in_valid held high:
  - err_sum=8, err_sq_sum=134, abs_sum=104, max_abs_err=10, sample_cnt=4.
  - done exactly 3 cycles after the 4th accept; in_ready low after the 4th accept.
- Same 4 pairs with in_valid toggling 1,0,1,0,... → identical results; done 3 cycles after the last accept.
- start with num_samples=0 → done the cycle after the next; all results 0; busy high for that one cycle.
- DATA_W=32, ACC_W=33, num_samples=3, appr=2^31-1, accu=-2^31 each sample:
  - err_sum saturates at 2^32-1 and ovf=1.
  - A following start clears ovf.
- rst asserted after 2 of 4 samples → next cycle all outputs 0, state IDLE, no done pulse.
- start=1 during RUN → ignored; latched N unchanged.
- Boundary: accu=-2^31 (DATA_W=32) → abs_sum contribution 2^31 exactly.
